credit_sender: RTL and testbench

Transmit end of the credit-based (valid/yummy) link terminated by the existing receiver block. Accepts 64-bit words from a local producer over a valid/ready handshake and buffers them in a small FIFO. Launches one word per cycle onto the link only while it holds a credit. Each yummy pulse from the far-end receiver returns one credit.

---
 rtl/metro_mpi_pkg.sv | 20 ++
 rtl/credit_sender_if.sv | 38 +++
 rtl/credit_fifo.sv | 60 ++++++
 rtl/credit_sender.sv | 88 ++++++++
 tb/tb_credit_sender.sv | 184 ++++++++++++++++++
 5 files changed

// File: rtl/metro_mpi_pkg.sv
// Shared definitions for the credit-based (valid/yummy) link: default
// widths and depths, a counter-width helper and the credit-count type
// used by both the sender and the receiver.
package metro_mpi_pkg;

   localparam int unsigned DATA_W_DEF      = 64;
   localparam int unsigned NUM_CREDITS_DEF = 4;
   localparam int unsigned FIFO_DEPTH_DEF  = 4;

   // Bits needed to hold every value from 0 up to and including max_val.
   function automatic int unsigned cnt_w(input int unsigned max_val);
      return $clog2(max_val + 1);
   endfunction

   localparam int unsigned CREDIT_W_DEF = cnt_w(NUM_CREDITS_DEF);

   // Credit count at the default link configuration.
   typedef logic [CREDIT_W_DEF-1:0] credit_cnt_t;

endpackage

// File: rtl/credit_sender_if.sv
// Bundle of the sender's producer handshake, link outputs and status.
// Signal names keep the sender-relative _i/_o suffixes so they read the
// same inside the block and at the link boundary.
interface credit_sender_if #(
   parameter int unsigned NUM_CREDITS = metro_mpi_pkg::NUM_CREDITS_DEF,
   parameter int unsigned FIFO_DEPTH  = metro_mpi_pkg::FIFO_DEPTH_DEF,
   parameter int unsigned DATA_W      = metro_mpi_pkg::DATA_W_DEF
);

   localparam int unsigned CRED_W = metro_mpi_pkg::cnt_w(NUM_CREDITS);
   localparam int unsigned CNT_W  = metro_mpi_pkg::cnt_w(FIFO_DEPTH);

   // producer handshake
   logic              valid_i;
   logic [DATA_W-1:0] data_i;
   logic              ready_o;
   // link towards the receiver
   logic              valid_o;
   logic [DATA_W-1:0] data_o;
   logic              yummy_i;
   // status
   logic [CRED_W-1:0] credits_o;
   logic [CNT_W-1:0]  count_o;
   logic              overflow_o;

   // Environment side: producer plus far-end receiver.
   modport master (
      output valid_i, data_i, yummy_i,
      input  ready_o, valid_o, data_o, credits_o, count_o, overflow_o
   );

   // Sender side.
   modport slave (
      input  valid_i, data_i, yummy_i,
      output ready_o, valid_o, data_o, credits_o, count_o, overflow_o
   );

endinterface

// File: rtl/credit_fifo.sv
// Single-clock synchronous FIFO buffering producer words until a credit
// allows them onto the link. The head word is visible combinationally.
module credit_fifo #(
   parameter  int unsigned DEPTH  = 4,
   parameter  int unsigned DATA_W = 64,
   localparam int unsigned PTR_W  = $clog2(DEPTH),
   localparam int unsigned CNT_W  = PTR_W + 1
) (
   input  logic              clk_i,
   input  logic              rstn_i,
   input  logic              push,
   input  logic              pop,
   input  logic [DATA_W-1:0] din,
   output logic [DATA_W-1:0] head,
   output logic              full,
   output logic              empty,
   output logic [CNT_W-1:0]  count
);

   localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

   logic [DATA_W-1:0] mem [DEPTH];
   logic [PTR_W-1:0]  wr_ptr;
   logic [PTR_W-1:0]  rd_ptr;
   logic [CNT_W-1:0]  cnt_q;
   logic              do_push;
   logic              do_pop;

   assign full    = (cnt_q == FULL_CNT);
   assign empty   = (cnt_q == '0);
   assign count   = cnt_q;
   assign head    = mem[rd_ptr];
   assign do_push = push && !full;
   assign do_pop  = pop && !empty;

   // Pointer and occupancy bookkeeping; pointers wrap because DEPTH is a power of two.
   always_ff @(posedge clk_i or negedge rstn_i) begin
      // NOTE: sequential state uses <= so every flop samples pre-edge values.
      if (!rstn_i) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         cnt_q  <= '0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + PTR_W'(1);
         if (do_pop)  rd_ptr <= rd_ptr + PTR_W'(1);
         case ({do_push, do_pop})
            2'b10:   cnt_q <= cnt_q + CNT_W'(1);
            2'b01:   cnt_q <= cnt_q - CNT_W'(1);
            default: cnt_q <= cnt_q;
         endcase
      end
   end

   // Word storage written at the tail.
   always_ff @(posedge clk_i) begin
      // NOTE: storage has no reset; cleared pointers and count make stale entries unreachable.
      if (do_push) mem[wr_ptr] <= din;
   end

endmodule

// File: rtl/credit_sender.sv
// Transmit end of the valid/yummy credit link. Buffers producer words,
// sends one per cycle while a credit is held, and takes back one credit
// per yummy pulse from the far-end receiver.
module credit_sender import metro_mpi_pkg::*; #(
   parameter int unsigned NUM_CREDITS = NUM_CREDITS_DEF,
   parameter int unsigned FIFO_DEPTH  = FIFO_DEPTH_DEF,
   parameter int unsigned DATA_W      = DATA_W_DEF
) (
   input  logic           clk_i,
   input  logic           rstn_i,
   credit_sender_if.slave bus
);

   localparam int unsigned      CRED_W   = cnt_w(NUM_CREDITS);
   localparam int unsigned      CNT_W    = cnt_w(FIFO_DEPTH);
   localparam logic [CRED_W-1:0] MAX_CRED = CRED_W'(NUM_CREDITS);

   logic              push;
   logic              send;
   logic              fifo_full;
   logic              fifo_empty;
   logic [DATA_W-1:0] head;
   logic [CNT_W-1:0]  fifo_count;

   logic [CRED_W-1:0] credits_q;
   logic [CRED_W-1:0] credits_d;
   logic              ovf_set;
   logic              overflow_q;
   logic              valid_q;
   logic [DATA_W-1:0] data_q;

   credit_fifo #(
      .DEPTH  (FIFO_DEPTH),
      .DATA_W (DATA_W)
   ) u_fifo (
      .clk_i  (clk_i),
      .rstn_i (rstn_i),
      .push   (push),
      .pop    (send),
      .din    (bus.data_i),
      .head   (head),
      .full   (fifo_full),
      .empty  (fifo_empty),
      .count  (fifo_count)
   );

   // ready depends only on registered occupancy, never on valid_i.
   assign push = bus.valid_i && !fifo_full;
   assign send = !fifo_empty && (credits_q != '0);

   assign bus.ready_o    = !fifo_full;
   assign bus.valid_o    = valid_q;
   assign bus.data_o     = data_q;
   assign bus.credits_o  = credits_q;
   assign bus.count_o    = fifo_count;
   assign bus.overflow_o = overflow_q;

   // Next credit count: spend one per send, regain one per yummy, saturate at the reset value.
   always_comb begin
      // NOTE: defaults first so no path leaves a signal unassigned and infers a latch.
      credits_d = credits_q;
      ovf_set   = 1'b0;
      case ({send, bus.yummy_i})
         2'b10: credits_d = credits_q - CRED_W'(1);
         2'b01: begin
            if (credits_q == MAX_CRED) ovf_set   = 1'b1;
            else                       credits_d = credits_q + CRED_W'(1);
         end
         default: credits_d = credits_q;
      endcase
   end

   // Credit counter, sticky overflow flag and the registered link output.
   always_ff @(posedge clk_i or negedge rstn_i) begin
      if (!rstn_i) begin
         credits_q  <= MAX_CRED;
         overflow_q <= 1'b0;
         valid_q    <= 1'b0;
         data_q     <= '0;
      end else begin
         credits_q <= credits_d;
         if (ovf_set) overflow_q <= 1'b1;
         valid_q <= send;
         if (send) data_q <= head;
      end
   end

endmodule

// File: tb/tb_credit_sender.sv
// Directed and randomized checks of credit_sender against a queue-based
// model of the link: words leave in arrival order, one per held credit.
module tb_credit_sender;
   import metro_mpi_pkg::*;

   localparam int unsigned NC = 4;
   localparam int unsigned FD = 4;
   localparam int unsigned DW = 64;

   logic clk  = 1'b0;
   logic rstn = 1'b0;

   credit_sender_if #(.NUM_CREDITS(NC), .FIFO_DEPTH(FD), .DATA_W(DW)) bus ();

   credit_sender #(.NUM_CREDITS(NC), .FIFO_DEPTH(FD), .DATA_W(DW)) dut (
      .clk_i  (clk),
      .rstn_i (rstn),
      .bus    (bus)
   );

   always #5 clk = ~clk;

   // Reference model: words waiting to be sent, credits held, expected outputs.
   logic [DW-1:0] m_q[$];
   int            m_cred;
   bit            m_ovf;
   bit            m_valid;
   logic [DW-1:0] m_data;

   int n_checks = 0;
   int n_fail   = 0;
   int pulses;

   task automatic check(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic model_reset();
      m_q.delete();
      m_cred  = NC;
      m_ovf   = 1'b0;
      m_valid = 1'b0;
      m_data  = '0;
   endtask

   task automatic check_state(input string tag);
      check({tag, "_valid"},    DW'(bus.valid_o),    DW'(m_valid));
      check({tag, "_data"},     bus.data_o,          m_data);
      check({tag, "_credits"},  DW'(bus.credits_o),  DW'(m_cred));
      check({tag, "_count"},    DW'(bus.count_o),    DW'(m_q.size()));
      check({tag, "_overflow"}, DW'(bus.overflow_o), DW'(m_ovf));
   endtask

   // One clock: drive at the falling edge, advance the model at the rising
   // edge, compare shortly after it.
   task automatic cycle(input string tag, input logic v, input logic [DW-1:0] d, input logic y);
      bit snd;
      bit psh;
      @(negedge clk);
      bus.valid_i = v;
      bus.data_i  = d;
      bus.yummy_i = y;
      check({tag, "_ready"}, DW'(bus.ready_o), DW'(m_q.size() < FD));
      snd = (m_q.size() > 0) && (m_cred > 0);
      psh = v && (m_q.size() < FD);
      @(posedge clk);
      m_valid = snd;
      if (snd) m_data = m_q.pop_front();
      if (psh) m_q.push_back(d);
      if (y && !snd && m_cred == NC) m_ovf = 1'b1;
      else                           m_cred = m_cred - int'(snd) + int'(y);
      #1;
      check_state(tag);
      if (bus.valid_o === 1'b1) pulses++;
   endtask

   initial begin
      int guard;
      logic          rv;
      logic          ry;
      logic [DW-1:0] rd;

      bus.valid_i = 1'b0;
      bus.data_i  = '0;
      bus.yummy_i = 1'b0;
      model_reset();

      // 1: reset state
      repeat (2) @(posedge clk);
      @(negedge clk);
      rstn = 1'b1;
      check("rst_ready", DW'(bus.ready_o), DW'(1));
      check_state("rst");

      // 2: four words with full credits go out in order, one edge after each push
      pulses = 0;
      for (int i = 0; i < 4; i++) cycle("t2", 1'b1, DW'(8'hA0 + i), 1'b0);
      cycle("t2_idle", 1'b0, '0, 1'b0);
      check("t2_pulses",  DW'(pulses),        DW'(4));
      check("t2_credits", DW'(bus.credits_o), DW'(0));

      // 3: no credits, FIFO fills and stalls; one yummy releases exactly one word
      for (int i = 0; i < 4; i++) cycle("t3_fill", 1'b1, DW'(8'hB0 + i), 1'b0);
      check("t3_full_count", DW'(bus.count_o), DW'(4));
      check("t3_full_ready", DW'(bus.ready_o), DW'(0));
      pulses = 0;
      cycle("t3_yummy", 1'b0, '0, 1'b1);
      for (int i = 0; i < 3; i++) cycle("t3_wait", 1'b0, '0, 1'b0);
      check("t3_pulses",  DW'(pulses),        DW'(1));
      check("t3_credits", DW'(bus.credits_o), DW'(0));
      check("t3_count",   DW'(bus.count_o),   DW'(3));

      // 4: credits=1, yummy during a send keeps the count; next word follows
      cycle("t4_yummy", 1'b0, '0, 1'b1);
      check("t4_one_credit", DW'(bus.credits_o), DW'(1));
      cycle("t4_send_yummy", 1'b0, '0, 1'b1);
      check("t4_credit_kept", DW'(bus.credits_o), DW'(1));
      check("t4_word_b1",     bus.data_o,         DW'(8'hB1));
      cycle("t4_next", 1'b0, '0, 1'b0);
      check("t4_word_b2", bus.data_o, DW'(8'hB2));

      // drain the FIFO and restore full credits without overflowing
      guard = 0;
      while ((m_q.size() > 0 || m_cred < NC) && guard < 20) begin
         cycle("drain", 1'b0, '0, m_cred < NC);
         guard++;
      end
      check("drain_done", DW'(guard < 20), DW'(1));

      // 5: yummy at full credits with nothing to send -> sticky overflow
      cycle("t5_ovf", 1'b0, '0, 1'b1);
      check("t5_overflow", DW'(bus.overflow_o), DW'(1));
      check("t5_credits",  DW'(bus.credits_o),  DW'(NC));
      for (int i = 0; i < 3; i++) cycle("t5_hold", 1'b0, '0, 1'b0);
      check("t5_sticky", DW'(bus.overflow_o), DW'(1));

      // 6: reset while count=3 and valid_o=1 flushes everything asynchronously
      for (int i = 0; i < 4; i++) cycle("t6_c", 1'b1, DW'(8'hC0 + i), 1'b0);
      cycle("t6_c_idle", 1'b0, '0, 1'b0);
      for (int i = 0; i < 4; i++) cycle("t6_d", 1'b1, DW'(8'hD0 + i), 1'b0);
      cycle("t6_yummy", 1'b0, '0, 1'b1);
      cycle("t6_send", 1'b0, '0, 1'b0);
      check("t6_pre_valid", DW'(bus.valid_o), DW'(1));
      check("t6_pre_count", DW'(bus.count_o), DW'(3));
      #1;
      rstn = 1'b0;
      model_reset();
      #1;
      check("t6_async_valid",    DW'(bus.valid_o),    DW'(0));
      check("t6_async_count",    DW'(bus.count_o),    DW'(0));
      check("t6_async_credits",  DW'(bus.credits_o),  DW'(NC));
      check("t6_async_overflow", DW'(bus.overflow_o), DW'(0));
      check("t6_async_ready",    DW'(bus.ready_o),    DW'(1));
      @(negedge clk);
      rstn = 1'b1;
      pulses = 0;
      for (int i = 0; i < 6; i++) cycle("t6_after", 1'b0, '0, 1'b0);
      check("t6_no_stale", DW'(pulses), DW'(0));

      // randomized traffic against the model
      for (int i = 0; i < 400; i++) begin
         rv = 1'($urandom_range(0, 1));
         rd = {$urandom, $urandom};
         ry = (m_cred < NC) ? 1'($urandom_range(0, 1)) : 1'($urandom_range(0, 15) == 0);
         cycle("rand", rv, rd, ry);
      end

      // return credits until every buffered word has left
      guard = 0;
      while (m_q.size() > 0 && guard < 50) begin
         cycle("rand_drain", 1'b0, '0, m_cred < NC);
         guard++;
      end
      check("rand_drained", DW'(bus.count_o), DW'(0));

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
